dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-side responder for the datapath's data-memory port: the other end of the `mem_read` / `mem_write` / `mem_byte_enable` request issued from `rv32i_control_word`. Holds a word-organised SRAM array and services one request at a time with a fixed, parameterised latency. It answers with a single-cycle `mem_resp` pulse. Used as the data-memory model in core-level simulation and as the scratchpad behind the MEM stage.

## Interface
- `DEPTH`, 1024 — number of 32-bit words; power of two, ≥ 2.
- `LATENCY`, 3 — cycles from request acceptance to `mem_resp`; ≥ 1.
- `clk`  in  1  — single clock, all state on rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `mem_read`  in  1  — read request; held high until `mem_resp`.
- `mem_write`  in  1  — write request; held high until `mem_resp`.
- `mem_address`  in  32  — byte address (`rv32i_word`); bits [1:0] ignored.
- `mem_wdata`  in  32  — write data, lane-aligned.
- `mem_byte_enable`  in  4  — write lane mask (`rv32i_mem_wmask`); bit i covers byte i; ignored on reads.
- `mem_resp`  out  1  — one-cycle completion pulse.
- `mem_rdata`  out  32  — read data, valid in the `mem_resp` cycle of a read; held until the next read completes.
- `err`  out  1  — sticky protocol-error flag.

## Operation
- Index = `mem_address[log2(DEPTH)+1:2]`. Upper bits are discarded, so the address wraps modulo DEPTH words. Array contents are not reset.
- FSM states:
  - IDLE: `mem_read|mem_write` high → latch address, wdata, mask and op; load the counter with LATENCY-1. Go to BUSY, or to RESP directly when LATENCY = 1.
  - BUSY: decrement the counter; at 0 go to RESP. If both request lines are low at any BUSY edge → abort to IDLE, nothing committed, no `mem_resp`.
  - RESP: `mem_resp` = 1 for this cycle only; next state IDLE, unconditionally.
- Commit happens on the edge entering RESP:
  - Read: the array word is registered into `mem_rdata`.
  - Write: only enabled byte lanes are updated; `mem_rdata` is unchanged.
  - Abort checks in the same edge take precedence over commit. If requests drop on the edge that would enter RESP, it is an abort.
- The latched address, data and mask are used for the commit. Input changes during BUSY other than dropping the request are ignored.
- Write with `mem_byte_enable = 4'b0000` completes normally with `mem_resp` and leaves the array unchanged.
- `mem_read` and `mem_write` both high when sampled in IDLE → `err` set (sticky until reset). The request is serviced as a write.
- Request still high in the cycle after RESP → treated as a new transaction. The requester must drop it in the `mem_resp` cycle to avoid a repeat.
- Reset (any time, including mid-BUSY/RESP) → IDLE, counter 0, pending op discarded.
  - `mem_resp` = 0, `mem_rdata` = 32'h0, `err` = 0.

## Timing
- Request first seen high in IDLE during cycle t → `mem_resp` high during cycle t+LATENCY, for exactly one cycle.
- Array update and `mem_rdata` are visible from cycle t+LATENCY.
- Minimum request-to-request spacing is LATENCY+1 cycles; throughput is one transaction per LATENCY+1 cycles.
- Read-after-write to the same word, issued back-to-back, returns the new data.
- All outputs are registered; no combinational path from inputs to `mem_resp`, `mem_rdata` or `err`.
- `rst_n` assertion clears outputs asynchronously; deassertion is synchronised by the environment.

## Test plan
- Reset: hold `rst_n` = 0 with `mem_read` = 1 → `mem_resp` = 0, `mem_rdata` = 0, `err` = 0. Release: the first resp arrives exactly LATENCY cycles after the first IDLE sample.
- Full word, LATENCY = 3: write 32'hDEADBEEF to 0x100 with mask 4'hF, then read 0x100 → each `mem_resp` arrives 3 cycles after request; read returns 32'hDEADBEEF.
- Byte lanes: after the above, write 32'h0000AA00 with mask 4'b0010 to 0x102, then read 0x100 → 32'hDEADAAEF.
- Abort: read 0x100, drop `mem_read` after 1 cycle → no `mem_resp`, `mem_rdata` unchanged. Next write aborted the same way leaves the array unchanged.
- Error/priority: `mem_read` = `mem_write` = 1, wdata 32'h12345678 to 0x8 → `err` = 1 and stays 1. A later read of 0x8 returns 32'h12345678.
- Wrap and repeat, DEPTH = 1024:
  - Write 32'h1 to address 0x1000, read 0x0 → 32'h1.
  - Hold `mem_read` high through resp → a second `mem_resp` arrives LATENCY+1 cycles after the first.

Source files
------------

// File: rtl/dmem_if.sv
// Data-memory request/response bundle between the datapath MEM stage and
// the memory-side responder.
interface dmem_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        err;

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  mem_resp, mem_rdata, err
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output mem_resp, mem_rdata, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data-memory responder with fixed request-to-response latency.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for mem_read/mem_write; request latched on acceptance
//   BUSY  | counting down latency; dropped request aborts with no commit
//   RESP  | single-cycle mem_resp; array/rdata already updated on entry
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 3
) (
    input  logic   clk,
    input  logic   rst_n,
    dmem_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      be_q;
    logic            wr_q;
    logic            resp_q;
    logic [31:0]     rdata_q;
    logic            err_q;
    logic [31:0]     mem_q [DEPTH];

    logic            req;
    logic [AW-1:0]   live_idx;
    logic            commit_idle;
    logic            commit_busy;
    logic            do_commit;
    logic [AW-1:0]   c_idx;
    logic [31:0]     c_wdata;
    logic [3:0]      c_be;
    logic            c_wr;

    // Commit select: with single-cycle latency the accepting edge is also the
    // commit edge, so live inputs are used instead of the latched copy.
    always_comb begin
        req         = bus.mem_read | bus.mem_write;
        live_idx    = bus.mem_address[AW+1:2];
        commit_idle = (LATENCY == 1) && (state_q == IDLE) && req;
        commit_busy = (state_q == BUSY) && req && (cnt_q == CW'(1));
        do_commit   = rst_n && (commit_idle || commit_busy);
        c_idx       = commit_idle ? live_idx          : addr_q;
        c_wdata     = commit_idle ? bus.mem_wdata     : wdata_q;
        c_be        = commit_idle ? bus.mem_byte_enable : be_q;
        c_wr        = commit_idle ? bus.mem_write     : wr_q;
    end

    // Byte-lane write into the array on the edge entering RESP; no reset.
    always_ff @(posedge clk) begin
        if (do_commit && c_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (c_be[i]) mem_q[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
            end
        end
    end

    // Sequencing FSM with registered resp/rdata/err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            resp_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q  <= live_idx;
                        wdata_q <= bus.mem_wdata;
                        be_q    <= bus.mem_byte_enable;
                        wr_q    <= bus.mem_write;
                        if (bus.mem_read && bus.mem_write) err_q <= 1'b1;
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                            resp_q  <= 1'b1;
                            cnt_q   <= '0;
                            if (!bus.mem_write) rdata_q <= mem_q[live_idx];
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= CW'(LATENCY - 1);
                        end
                    end
                end
                BUSY: begin
                    if (!req) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CW'(1)) begin
                        state_q <= RESP;
                        resp_q  <= 1'b1;
                        cnt_q   <= '0;
                        if (!wr_q) rdata_q <= mem_q[addr_q];
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_resp  = resp_q;
    assign bus.mem_rdata = rdata_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized traffic checked
// against a word-array model of the memory.
module tb_dmem_responder;
    localparam int DEPTH = 1024;
    localparam int LAT   = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_if bus ();

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] model [int];
    logic [31:0] exp_rdata;
    logic        exp_err;

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    // Reference behaviour of one completed transaction.
    task automatic model_apply(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [3:0] be);
        int k;
        logic [31:0] w;
        k = widx(addr);
        if (rd && wr) exp_err = 1'b1;
        if (wr) begin
            w = model.exists(k) ? model[k] : 32'hxxxxxxxx;
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
            model[k] = w;
        end else begin
            exp_rdata = model[k];
        end
    endtask

    task automatic idle_bus();
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    // Drives one request, waits for mem_resp (bounded), drops the request in
    // the resp cycle and samples mem_resp one cycle later.
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] be,
                           output int lat, output logic [31:0] rdata, output logic resp_after);
        bit got;
        @(negedge clk);
        bus.mem_read = rd;
        bus.mem_write = wr;
        bus.mem_address = addr;
        bus.mem_wdata = wd;
        bus.mem_byte_enable = be;
        lat = 0;
        got = 0;
        while (!got && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (bus.mem_resp === 1'b1) got = 1;
        end
        if (!got) lat = -1;
        rdata = bus.mem_rdata;
        idle_bus();
        @(posedge clk); #1;
        resp_after = bus.mem_resp;
    endtask

    task automatic test_reset();
        int lat;
        bit got;
        rst_n = 1'b0;
        bus.mem_read = 1'b1;
        bus.mem_write = 1'b0;
        bus.mem_address = 32'h40;
        bus.mem_wdata = 32'h0;
        bus.mem_byte_enable = 4'h0;
        repeat (3) @(negedge clk);
        checks++; if (bus.mem_resp !== 1'b0) begin errors++; $display("FAIL reset_resp got %b want 0", bus.mem_resp); end
        checks++; if (bus.mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", bus.mem_rdata); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err); end
        rst_n = 1'b1;
        lat = 0; got = 0;
        while (!got && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (bus.mem_resp === 1'b1) got = 1;
        end
        checks++; if (!got || lat != LAT) begin errors++; $display("FAIL reset_first_lat got %0d want %0d", got ? lat : -1, LAT); end
        idle_bus();
        @(posedge clk); #1;
        exp_rdata = bus.mem_rdata;
        exp_err = 1'b0;
    endtask

    task automatic test_full_word();
        int lat; logic [31:0] rd; logic ra;
        run_txn(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, lat, rd, ra);
        model_apply(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
        checks++; if (lat != LAT) begin errors++; $display("FAIL full_wr_lat got %0d want %0d", lat, LAT); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL full_wr_pulse got %b want 0", ra); end
        run_txn(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, lat, rd, ra);
        model_apply(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        checks++; if (lat != LAT) begin errors++; $display("FAIL full_rd_lat got %0d want %0d", lat, LAT); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL full_rd_pulse got %b want 0", ra); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL full_rd_data got %h want deadbeef", rd); end
    endtask

    task automatic test_byte_lanes();
        int lat; logic [31:0] rd; logic ra;
        run_txn(1'b0, 1'b1, 32'h102, 32'h0000AA00, 4'b0010, lat, rd, ra);
        model_apply(1'b0, 1'b1, 32'h102, 32'h0000AA00, 4'b0010);
        run_txn(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, lat, rd, ra);
        model_apply(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        checks++; if (rd !== 32'hDEADAAEF) begin errors++; $display("FAIL lanes_rd got %h want deadaaef", rd); end
        run_txn(1'b0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'h0, lat, rd, ra);
        model_apply(1'b0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'h0);
        checks++; if (lat != LAT) begin errors++; $display("FAIL lanes_zero_mask_lat got %0d want %0d", lat, LAT); end
        run_txn(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, lat, rd, ra);
        model_apply(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        checks++; if (rd !== exp_rdata) begin errors++; $display("FAIL lanes_zero_mask_rd got %h want %h", rd, exp_rdata); end
    endtask

    // Holds the request for 'held' sampling edges, then drops it.
    task automatic abort_txn(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input int held, output int resp_seen);
        @(negedge clk);
        bus.mem_read = rd;
        bus.mem_write = wr;
        bus.mem_address = addr;
        bus.mem_wdata = wd;
        bus.mem_byte_enable = 4'hF;
        resp_seen = 0;
        repeat (held) begin
            @(posedge clk); #1;
            if (bus.mem_resp === 1'b1) resp_seen++;
            @(negedge clk);
        end
        idle_bus();
        repeat (LAT + 3) begin
            @(posedge clk); #1;
            if (bus.mem_resp === 1'b1) resp_seen++;
        end
    endtask

    task automatic test_abort();
        int lat; logic [31:0] rd; logic ra; int seen;
        run_txn(1'b0, 1'b1, 32'h200, 32'h55AA1234, 4'hF, lat, rd, ra);
        model_apply(1'b0, 1'b1, 32'h200, 32'h55AA1234, 4'hF);
        for (int h = 1; h <= LAT - 1; h++) begin
            abort_txn(1'b1, 1'b0, 32'h200, 32'h0, h, seen);
            checks++; if (seen != 0) begin errors++; $display("FAIL abort_rd_resp held %0d got %0d pulses want 0", h, seen); end
            checks++; if (bus.mem_rdata !== exp_rdata) begin errors++; $display("FAIL abort_rd_data held %0d got %h want %h", h, bus.mem_rdata, exp_rdata); end
            abort_txn(1'b0, 1'b1, 32'h100, 32'h13572468, h, seen);
            checks++; if (seen != 0) begin errors++; $display("FAIL abort_wr_resp held %0d got %0d pulses want 0", h, seen); end
        end
        run_txn(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, lat, rd, ra);
        model_apply(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        checks++; if (rd !== exp_rdata) begin errors++; $display("FAIL abort_wr_array got %h want %h", rd, exp_rdata); end
    endtask

    task automatic test_wrap_repeat();
        int lat; logic [31:0] rd; logic ra; int gap; bit got;
        run_txn(1'b0, 1'b1, 32'h1000, 32'h1, 4'hF, lat, rd, ra);
        model_apply(1'b0, 1'b1, 32'h1000, 32'h1, 4'hF);
        run_txn(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, lat, rd, ra);
        model_apply(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL wrap_rd got %h want 00000001", rd); end
        @(negedge clk);
        bus.mem_read = 1'b1;
        bus.mem_address = 32'h1000;
        lat = 0; got = 0;
        while (!got && lat < 20) begin
            @(posedge clk); #1; lat++;
            if (bus.mem_resp === 1'b1) got = 1;
        end
        checks++; if (!got || lat != LAT) begin errors++; $display("FAIL repeat_first_lat got %0d want %0d", got ? lat : -1, LAT); end
        gap = 0; got = 0;
        while (!got && gap < 20) begin
            @(posedge clk); #1; gap++;
            if (bus.mem_resp === 1'b1) got = 1;
        end
        checks++; if (!got || gap != LAT + 1) begin errors++; $display("FAIL repeat_gap got %0d want %0d", got ? gap : -1, LAT + 1); end
        checks++; if (bus.mem_rdata !== 32'h1) begin errors++; $display("FAIL repeat_rd got %h want 00000001", bus.mem_rdata); end
        idle_bus();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic ra;
        run_txn(1'b0, 1'b1, 32'h300, 32'hA5A5A5A5, 4'hF, lat, rd, ra);
        model_apply(1'b0, 1'b1, 32'h300, 32'hA5A5A5A5, 4'hF);
        run_txn(1'b1, 1'b0, 32'h300, 32'h0, 4'h0, lat, rd, ra);
        model_apply(1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
        @(negedge clk);
        bus.mem_write = 1'b1;
        bus.mem_read = 1'b1;
        bus.mem_address = 32'h300;
        bus.mem_wdata = 32'h0;
        bus.mem_byte_enable = 4'hF;
        repeat (LAT - 1) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_resp !== 1'b0) begin errors++; $display("FAIL mid_reset_resp got %b want 0", bus.mem_resp); end
        checks++; if (bus.mem_rdata !== 32'h0) begin errors++; $display("FAIL mid_reset_rdata got %h want 0", bus.mem_rdata); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL mid_reset_err got %b want 0", bus.err); end
        idle_bus();
        @(negedge clk);
        rst_n = 1'b1;
        exp_rdata = 32'h0;
        exp_err = 1'b0;
        run_txn(1'b1, 1'b0, 32'h300, 32'h0, 4'h0, lat, rd, ra);
        model_apply(1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
        checks++; if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL mid_reset_array got %h want a5a5a5a5", rd); end
    endtask

    task automatic test_error();
        int lat; logic [31:0] rd; logic ra;
        run_txn(1'b1, 1'b1, 32'h8, 32'h12345678, 4'hF, lat, rd, ra);
        model_apply(1'b1, 1'b1, 32'h8, 32'h12345678, 4'hF);
        checks++; if (lat != LAT) begin errors++; $display("FAIL err_lat got %0d want %0d", lat, LAT); end
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", bus.err); end
        run_txn(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, lat, rd, ra);
        model_apply(1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL err_wr_prio got %h want 12345678", rd); end
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", bus.err); end
    endtask

    task automatic test_random();
        int lat; logic [31:0] rd; logic ra;
        logic [31:0] addr, wd;
        logic [3:0] be;
        logic op_rd;
        for (int i = 0; i < 16; i++) begin
            addr = (32'($urandom_range(0, 7)) << 12) | (32'(i) << 2);
            wd = $urandom;
            run_txn(1'b0, 1'b1, addr, wd, 4'hF, lat, rd, ra);
            model_apply(1'b0, 1'b1, addr, wd, 4'hF);
        end
        for (int n = 0; n < 60; n++) begin
            addr = (32'($urandom_range(0, 7)) << 12) | (32'($urandom_range(0, 15)) << 2)
                   | 32'($urandom_range(0, 3));
            wd = $urandom;
            be = 4'($urandom_range(0, 15));
            op_rd = 1'($urandom_range(0, 1));
            run_txn(op_rd, !op_rd, addr, wd, be, lat, rd, ra);
            model_apply(op_rd, !op_rd, addr, wd, be);
            checks++; if (lat != LAT || ra !== 1'b0) begin errors++; $display("FAIL rand_timing n=%0d lat %0d pulse %b want %0d/0", n, lat, ra, LAT); end
            checks++; if (rd !== exp_rdata) begin errors++; $display("FAIL rand_rdata n=%0d addr %h got %h want %h", n, addr, rd, exp_rdata); end
            checks++; if (bus.err !== exp_err) begin errors++; $display("FAIL rand_err n=%0d got %b want %b", n, bus.err, exp_err); end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        idle_bus();
        bus.mem_address = 32'h0;
        bus.mem_wdata = 32'h0;
        bus.mem_byte_enable = 4'h0;
        exp_rdata = 32'h0;
        exp_err = 1'b0;
        test_reset();
        test_full_word();
        test_byte_lanes();
        test_abort();
        test_wrap_repeat();
        test_reset_mid();
        test_error();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
